// File: rtl/mpa_core_pkg.sv
// mpa_core_pkg
// Shared constants and types for the multi-precision add/sub stream unit:
//   - command word bit positions (op, swap, unit id field)
//   - FSM state encoding
//   - default limb width / control width / limb-count limits
package mpa_core_pkg;

  // Command word layout (channel A): [7]=op, [6]=swap, [5:0]=unit id.
  localparam int OP_BIT   = 7;
  localparam int SWAP_BIT = 6;
  localparam int ID_W     = 6;

  // Operation encoding carried in OP_BIT.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width and limb-count defaults. Limb width must be 16, 32 or 64.
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_CTRL_WIDTH = 8;
  localparam int DEF_ID         = 3;
  localparam int DEF_MAX_LIMBS  = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD2 = 2'd1,
    RUN  = 2'd2,
    TAIL = 2'd3
  } mpa_state_e;

  // Width of a counter able to hold 0..max_limbs inclusive.
  function automatic int cnt_width(input int max_limbs);
    return $clog2(max_limbs + 1);
  endfunction

endpackage

// File: rtl/mpa_limb_addsub.sv
// mpa_limb_addsub
// Combinational single-limb adder/subtractor.
//   a_i, b_i : operand limbs
//   c_i      : carry in (add) or borrow in (sub)
//   sub_i    : 0 -> s_o = a+b+c_i, 1 -> s_o = a-b-c_i
//   s_o      : result limb
//   c_o      : carry out (add) or borrow out (sub)
module mpa_limb_addsub #(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  input  logic         sub_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);

  logic [W:0]   sum;
  logic [W-1:0] b_eff;
  logic         c_eff;

  // Subtraction as a + ~b + ~borrow_in; the adder carry then means "no borrow".
  always_comb begin
    b_eff = sub_i ? ~b_i : b_i;
    c_eff = sub_i ? ~c_i : c_i;
    sum   = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, c_eff};
    s_o   = sum[W-1:0];
    c_o   = sub_i ? ~sum[W] : sum[W];
  end

endmodule

// File: rtl/mpa_addsub_stream.sv
// mpa_addsub_stream
// Streaming multi-precision add/subtract. A two-word command selects the
// operation, then operand limb pairs arrive least significant first; each
// accepted pair yields one registered output limb a cycle later, followed by a
// final carry/borrow limb flagged with po_data_last.
//   r_clk, r_rst             : clock, synchronous active-high reset
//   pi_ctrl_ch_A/B, _valid_n : command words (valid active-low)
//   pi_data_A/B, _wr_en, _last: operand limb stream
//   po_data_lo/up            : main result (A+B or X-Y) / reverse difference (Y-X)
//   po_data_wr_en, _last     : output limb valid / carry limb marker
//   po_data_all_ones, _zero  : whole-result flags, valid with po_data_last
//   po_busy                  : unit not idle
//   po_limb_cnt              : output limbs emitted, saturating at G_MAX_LIMBS
module mpa_addsub_stream
  import mpa_core_pkg::*;
#(
  parameter int G_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int G_CTRL_WIDTH = DEF_CTRL_WIDTH,
  parameter int G_ID         = DEF_ID,
  parameter int G_MAX_LIMBS  = DEF_MAX_LIMBS
) (
  input  logic                                  r_clk,
  input  logic                                  r_rst,
  input  logic [G_CTRL_WIDTH-1:0]               pi_ctrl_ch_A,
  input  logic [G_CTRL_WIDTH-1:0]               pi_ctrl_ch_B,
  input  logic                                  pi_ctrl_valid_n,
  input  logic [G_DATA_WIDTH-1:0]               pi_data_A,
  input  logic [G_DATA_WIDTH-1:0]               pi_data_B,
  input  logic                                  pi_data_wr_en,
  input  logic                                  pi_data_last,
  output logic [G_DATA_WIDTH-1:0]               po_data_lo,
  output logic [G_DATA_WIDTH-1:0]               po_data_up,
  output logic                                  po_data_wr_en,
  output logic                                  po_data_last,
  output logic                                  po_data_all_ones,
  output logic [1:0]                            po_data_zero,
  output logic                                  po_busy,
  output logic [$clog2(G_MAX_LIMBS+1)-1:0]      po_limb_cnt
);

  localparam int W     = G_DATA_WIDTH;
  localparam int CNT_W = $clog2(G_MAX_LIMBS + 1);
  localparam logic [ID_W-1:0]  ID_L    = ID_W'(G_ID);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(G_MAX_LIMBS);

  // State and operation context
  mpa_state_e       state_q;
  logic             op_q, swap_q;
  logic             cy_lo_q, cy_up_q;

  // Registered outputs
  logic [W-1:0]     lo_q, up_q;
  logic             wr_q, last_q;
  logic [1:0]       zero_q;
  logic             ones_q;
  logic [CNT_W-1:0] cnt_q;

  // Datapath
  logic [W-1:0]     op_x, op_y;
  logic [W-1:0]     lo_sum, up_sum;
  logic             lo_co, up_co;
  logic [W-1:0]     tail_lo, tail_up;
  logic [W-1:0]     out_lo_d, out_up_d;
  logic             cy_lo_d, cy_up_d;
  logic             emit_d;
  logic             cmd_hit;

  // Only the low control bits carry meaning; the rest are intentionally dropped.
  logic             unused_ctrl;
  assign unused_ctrl = ^{pi_ctrl_ch_A, pi_ctrl_ch_B};

  assign cmd_hit = !pi_ctrl_valid_n &&
                   (pi_ctrl_ch_A[ID_W-1:0] == ID_L) &&
                   (pi_ctrl_ch_B[ID_W-1:0] == ID_L);

  // Swap only matters for subtraction; addition is commutative.
  assign op_x = swap_q ? pi_data_B : pi_data_A;
  assign op_y = swap_q ? pi_data_A : pi_data_B;

  // lo: X op Y with its own carry/borrow chain
  mpa_limb_addsub #(.W(W)) u_lo (
    .a_i   (op_x),
    .b_i   (op_y),
    .c_i   (cy_lo_q),
    .sub_i (op_q),
    .s_o   (lo_sum),
    .c_o   (lo_co)
  );

  // up: Y - X, only meaningful for subtraction
  mpa_limb_addsub #(.W(W)) u_up (
    .a_i   (op_y),
    .b_i   (op_x),
    .c_i   (cy_up_q),
    .sub_i (1'b1),
    .s_o   (up_sum),
    .c_o   (up_co)
  );

  // Carry limb: add -> carry as 0/1, sub -> borrow sign-extended to all-ones.
  always_comb begin
    tail_lo = '0;
    tail_up = '0;
    if (op_q == OP_SUB) begin
      tail_lo = {W{cy_lo_q}};
      tail_up = {W{cy_up_q}};
    end else begin
      tail_lo = {{(W-1){1'b0}}, cy_lo_q};
    end
  end

  always_comb begin
    emit_d   = 1'b0;
    out_lo_d = lo_sum;
    out_up_d = (op_q == OP_SUB) ? up_sum : '0;
    cy_lo_d  = lo_co;
    cy_up_d  = (op_q == OP_SUB) ? up_co : 1'b0;
    unique case (state_q)
      RUN:  emit_d = pi_data_wr_en;
      TAIL: begin
        emit_d   = 1'b1;
        out_lo_d = tail_lo;
        out_up_d = tail_up;
        cy_lo_d  = 1'b0;
        cy_up_d  = 1'b0;
      end
      default: emit_d = 1'b0;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      swap_q  <= 1'b0;
      cy_lo_q <= 1'b0;
      cy_up_q <= 1'b0;
      lo_q    <= '0;
      up_q    <= '0;
      wr_q    <= 1'b0;
      last_q  <= 1'b0;
      zero_q  <= 2'b11;
      ones_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wr_q   <= 1'b0;
      last_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          // Data arriving alongside a command is dropped.
          if (cmd_hit) begin
            state_q <= CMD2;
            op_q    <= pi_ctrl_ch_A[OP_BIT];
            swap_q  <= pi_ctrl_ch_A[SWAP_BIT];
            cy_lo_q <= 1'b0;
            cy_up_q <= 1'b0;
            zero_q  <= 2'b11;
            ones_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        CMD2: state_q <= RUN;   // second command word carries nothing we use
        RUN: begin
          if (pi_data_wr_en && pi_data_last) state_q <= TAIL;
        end
        TAIL: begin
          last_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (emit_d) begin
        lo_q    <= out_lo_d;
        up_q    <= out_up_d;
        wr_q    <= 1'b1;
        cy_lo_q <= cy_lo_d;
        cy_up_q <= cy_up_d;
        // Flags accumulate over every emitted limb, carry limb included.
        zero_q[0] <= zero_q[0] & (out_lo_d == '0);
        zero_q[1] <= zero_q[1] & (out_up_d == '0);
        ones_q    <= ones_q & (out_lo_d == {W{1'b1}});
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign po_data_lo       = lo_q;
  assign po_data_up       = up_q;
  assign po_data_wr_en    = wr_q;
  assign po_data_last     = last_q;
  assign po_data_all_ones = ones_q;
  assign po_data_zero     = zero_q;
  assign po_busy          = (state_q != IDLE);
  assign po_limb_cnt      = cnt_q;

endmodule

// File: tb/tb_mpa_addsub_stream.sv
module tb_mpa_addsub_stream;
  localparam int W  = 64;
  localparam int CW = 8;
  localparam int ID = 3;
  localparam int ML = 512;
  localparam int NW = $clog2(ML + 1);
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic          r_clk, r_rst;
  logic [CW-1:0] ctrl_a, ctrl_b;
  logic          ctrl_vn;
  logic [W-1:0]  da, db;
  logic          dwr, dlast;
  logic [W-1:0]  lo, up;
  logic          owr, olast, oones, obusy;
  logic [1:0]    ozero;
  logic [NW-1:0] ocnt;

  mpa_addsub_stream #(
    .G_DATA_WIDTH(W), .G_CTRL_WIDTH(CW), .G_ID(ID), .G_MAX_LIMBS(ML)
  ) dut (
    .r_clk(r_clk), .r_rst(r_rst),
    .pi_ctrl_ch_A(ctrl_a), .pi_ctrl_ch_B(ctrl_b), .pi_ctrl_valid_n(ctrl_vn),
    .pi_data_A(da), .pi_data_B(db), .pi_data_wr_en(dwr), .pi_data_last(dlast),
    .po_data_lo(lo), .po_data_up(up), .po_data_wr_en(owr), .po_data_last(olast),
    .po_data_all_ones(oones), .po_data_zero(ozero), .po_busy(obusy),
    .po_limb_cnt(ocnt)
  );

  typedef struct {
    logic [W-1:0]  lo;
    logic [W-1:0]  up;
    logic          last;
    logic [NW-1:0] cnt;
    logic [1:0]    z;
    logic          ao;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int n_tests = 0;
  int n_fail  = 0;

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: every output limb is matched against the scoreboard head.
  always @(negedge r_clk) begin
    if (owr === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: lo=%h up=%h last=%b expected no output", lo, up, olast);
      end else begin
        mon_e = q.pop_front();
        check("lo", lo, mon_e.lo);
        check("up", up, mon_e.up);
        check("last", W'(olast), W'(mon_e.last));
        check("limb_cnt", W'(ocnt), W'(mon_e.cnt));
        if (mon_e.last) begin
          check("zero", W'(ozero), W'(mon_e.z));
          check("all_ones", W'(oones), W'(mon_e.ao));
        end
      end
    end
  end

  task automatic tick;
    @(posedge r_clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] l, input logic [W-1:0] u, input logic lst,
                      input int cnt, input logic [1:0] z, input logic ao);
    exp_t e;
    e.lo = l; e.up = u; e.last = lst; e.cnt = NW'(cnt); e.z = z; e.ao = ao;
    q.push_back(e);
  endtask

  // Command pulse then the CMD2 cycle; optional junk data must be dropped.
  task automatic send_cmd(input logic op, input logic sw, input logic [5:0] ida,
                          input logic [5:0] idb, input logic with_data);
    ctrl_a  = {op, sw, ida};
    ctrl_b  = {2'b00, idb};
    ctrl_vn = 1'b0;
    if (with_data) begin
      da = 64'hDEAD_BEEF_0BAD_F00D; db = 64'h1234; dwr = 1'b1;
    end
    tick;
    ctrl_vn = 1'b1;
    tick;
    dwr = 1'b0;
  endtask

  task automatic send_limb(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic lst, input int gap);
    repeat (gap) tick;
    da = a; db = b; dwr = 1'b1; dlast = lst;
    tick;
    dwr = 1'b0; dlast = 1'b0;
    check("latency", W'(owr), W'(1'b1));
  endtask

  task automatic drain;
    int k = 0;
    while (q.size() != 0 && k < 20) begin
      tick;
      k++;
    end
    tick;
    check("drain_queue_empty", W'(q.size()), '0);
    check("idle_after_op", W'(obusy), '0);
  endtask

  logic [319:0] ma, mb, ms;
  logic [W-1:0] al [4];
  logic [W-1:0] bl [4];

  initial begin
    r_rst = 1'b1; ctrl_a = '0; ctrl_b = '0; ctrl_vn = 1'b1;
    da = '0; db = '0; dwr = 1'b0; dlast = 1'b0;
    tick; tick;
    r_rst = 1'b0;
    check("rst_lo", lo, '0);
    check("rst_up", up, '0);
    check("rst_wr", W'(owr), '0);
    check("rst_last", W'(olast), '0);
    check("rst_busy", W'(obusy), '0);
    check("rst_cnt", W'(ocnt), '0);
    check("rst_zero", W'(ozero), W'(2'b11));
    check("rst_ones", W'(oones), '0);

    // 1-limb add with full carry propagation
    send_cmd(1'b0, 1'b0, 6'd3, 6'd3, 1'b0);
    push('0, '0, 1'b0, 1, 2'b00, 1'b0);
    push(64'd1, '0, 1'b1, 2, 2'b10, 1'b0);
    send_limb(ONES, 64'd1, 1'b1, 0);
    drain;

    // 1-limb sub 1-2: lo borrows, up = 2-1
    send_cmd(1'b1, 1'b0, 6'd3, 6'd3, 1'b0);
    push(ONES, 64'd1, 1'b0, 1, 2'b00, 1'b0);
    push(ONES, '0, 1'b1, 2, 2'b00, 1'b1);
    send_limb(64'd1, 64'd2, 1'b1, 0);
    drain;

    // 3-limb equal-operand sub, then swapped with data coinciding with command
    for (int s = 0; s < 2; s++) begin
      send_cmd(1'b1, s[0], 6'd3, 6'd3, s[0]);
      for (int i = 0; i < 3; i++) push('0, '0, 1'b0, i + 1, 2'b11, 1'b0);
      push('0, '0, 1'b1, 4, 2'b11, 1'b0);
      for (int i = 0; i < 3; i++) send_limb(64'd5, 64'd5, (i == 2), 0);
      drain;
    end

    // 4-limb add with 0..3 idle cycles between pairs, checked against a bignum sum
    al[0] = ONES;                  bl[0] = 64'd1;
    al[1] = 64'h0123_4567_89AB_CDEF; bl[1] = 64'hFEDC_BA98_7654_3210;
    al[2] = ONES;                  bl[2] = 64'd0;
    al[3] = 64'h8000_0000_0000_0000; bl[3] = 64'h8000_0000_0000_0000;
    ma = {64'd0, al[3], al[2], al[1], al[0]};
    mb = {64'd0, bl[3], bl[2], bl[1], bl[0]};
    ms = ma + mb;
    send_cmd(1'b0, 1'b0, 6'd3, 6'd3, 1'b0);
    for (int i = 0; i < 5; i++)
      push(ms[64*i +: 64], '0, (i == 4), i + 1, {1'b1, (ms == '0)}, (&ms[255:0]) && (ms[319:256] == ONES));
    for (int i = 0; i < 4; i++) send_limb(al[i], bl[i], (i == 3), i);
    drain;

    // Reset while the third of five limbs is offered
    send_cmd(1'b0, 1'b0, 6'd3, 6'd3, 1'b0);
    push(64'd30, '0, 1'b0, 1, 2'b00, 1'b0);
    push(64'd3, '0, 1'b0, 2, 2'b00, 1'b0);
    send_limb(64'd10, 64'd20, 1'b0, 0);
    send_limb(64'd1, 64'd2, 1'b0, 0);
    da = 64'd7; db = 64'd7; dwr = 1'b1; r_rst = 1'b1;
    tick;
    r_rst = 1'b0; dwr = 1'b0;
    check("abort_lo", lo, '0);
    check("abort_wr", W'(owr), '0);
    check("abort_last", W'(olast), '0);
    check("abort_busy", W'(obusy), '0);
    check("abort_cnt", W'(ocnt), '0);
    check("abort_zero", W'(ozero), W'(2'b11));
    check("abort_ones", W'(oones), '0);
    tick;
    send_cmd(1'b0, 1'b0, 6'd3, 6'd3, 1'b0);
    push(64'd5, '0, 1'b0, 1, 2'b00, 1'b0);
    push('0, '0, 1'b1, 2, 2'b10, 1'b0);
    send_limb(64'd2, 64'd3, 1'b1, 0);
    drain;

    // Command with the wrong id is ignored
    ctrl_a = {2'b00, 6'd5}; ctrl_b = {2'b00, 6'd3}; ctrl_vn = 1'b0;
    tick;
    ctrl_vn = 1'b1;
    check("bad_id_busy", W'(obusy), '0);
    tick;
    check("bad_id_busy2", W'(obusy), '0);

    // A sub command issued mid-operation must not disturb the running add
    send_cmd(1'b0, 1'b0, 6'd3, 6'd3, 1'b0);
    push(64'd15, '0, 1'b0, 1, 2'b00, 1'b0);
    push(64'd2, '0, 1'b0, 2, 2'b00, 1'b0);
    push('0, '0, 1'b1, 3, 2'b10, 1'b0);
    send_limb(64'd7, 64'd8, 1'b0, 0);
    ctrl_a = {1'b1, 1'b1, 6'd3}; ctrl_b = {2'b00, 6'd3}; ctrl_vn = 1'b0;
    tick;
    ctrl_vn = 1'b1;
    check("busy_cmd_busy", W'(obusy), W'(1'b1));
    send_limb(64'd1, 64'd1, 1'b1, 1);
    drain;

    repeat (3) tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
